// File: rtl/fb_pkg.sv
// Shared types and geometry for the LED framebuffer arbiter.
// The optional brightness stage is enabled with the FB_BRIGHTNESS_EN macro.
package fb_pkg;

  localparam int unsigned FB_NUM_REQ    = 2;
  localparam int unsigned FB_CH_PER_REQ = 216;
  localparam int unsigned FB_DATA_W     = 8;
  localparam int unsigned FB_AW         = $clog2(FB_NUM_REQ * FB_CH_PER_REQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_SCALE,
    ST_RESP
  } fb_state_e;

  // First global byte owned by requester i.
  function automatic logic [FB_AW-1:0] base_addr(input int unsigned i);
    return FB_AW'(i * FB_CH_PER_REQ);
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one synchronous read port,
// read returns the old byte when both ports hit the same address on one edge.
module fb_ram #(
  parameter int unsigned DEPTH  = 432,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the array has no reset so it maps onto block RAM; contents survive resetn.
  // NOTE: non-blocking assignments make the read sample the array before the
  // same-edge write lands, which is exactly the read-old-data behaviour.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/framebuffer_arbiter.sv
// Round-robin byte-read arbiter in front of the LED framebuffer RAM, with free-running writes.
// Define FB_BRIGHTNESS_EN to add the brightness port and the SCALE pipeline stage.
module framebuffer_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = FB_NUM_REQ,
  parameter int unsigned CH_PER_REQ = FB_CH_PER_REQ,
  parameter int unsigned DATA_W     = FB_DATA_W,
  parameter int unsigned LOCAL_AW   = $clog2(CH_PER_REQ),
  parameter int unsigned AW         = $clog2(NUM_REQ * CH_PER_REQ)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*LOCAL_AW-1:0]  req_addr,
`ifdef FB_BRIGHTNESS_EN
  input  logic [7:0]                   brightness,
`endif
  output logic [NUM_REQ-1:0]           rsp_rdy,
  output logic [DATA_W-1:0]            rsp_data
);

  localparam int unsigned DEPTH = NUM_REQ * CH_PER_REQ;
  localparam int unsigned PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  fb_state_e         state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gnt_q, gnt_d;
  logic              oob_q, oob_d;
  logic [NUM_REQ-1:0] rsp_rdy_q, rsp_rdy_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
`ifdef FB_BRIGHTNESS_EN
  logic [DATA_W-1:0] data_q, data_d;
  logic [15:0]       prod;
`endif

  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic              found;
  int                cand;
  logic [LOCAL_AW-1:0] loc;

  fb_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    oob_d      = oob_q;
    rsp_rdy_d  = '0;
    rsp_data_d = rsp_data_q;
    rd_en      = 1'b0;
    rd_addr    = '0;
    found      = 1'b0;
    cand       = 0;
    loc        = '0;
`ifdef FB_BRIGHTNESS_EN
    data_d     = data_q;
    prod       = 16'(data_q) * (16'(brightness) + 16'd1);
`endif

    case (state_q)
      ST_IDLE: begin
        // Search starts at the pointer so the last winner has lowest priority.
        for (int off = 0; off < int'(NUM_REQ); off++) begin
          cand = (int'(ptr_q) + off) % int'(NUM_REQ);
          if (!found && req[cand]) begin
            found = 1'b1;
            gnt_d = PW'(cand);
            loc   = req_addr[cand*LOCAL_AW +: LOCAL_AW];
          end
        end
        if (found) begin
          oob_d   = (32'(loc) >= CH_PER_REQ);
          rd_en   = !oob_d;
          rd_addr = AW'(base_addr(32'(gnt_d))) + AW'(loc);
          state_d = ST_READ;
        end
      end

      ST_READ: begin
`ifdef FB_BRIGHTNESS_EN
        data_d  = oob_q ? '0 : ram_rd_data;
        state_d = ST_SCALE;
`else
        rsp_rdy_d[gnt_q] = 1'b1;
        rsp_data_d       = oob_q ? '0 : ram_rd_data;
        state_d          = ST_RESP;
`endif
      end

`ifdef FB_BRIGHTNESS_EN
      ST_SCALE: begin
        rsp_rdy_d[gnt_q] = 1'b1;
        rsp_data_d       = DATA_W'(prod >> 8);
        state_d          = ST_RESP;
      end
`endif

      ST_RESP: begin
        ptr_d   = (gnt_q == PW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      oob_q      <= 1'b0;
      rsp_rdy_q  <= '0;
      rsp_data_q <= '0;
`ifdef FB_BRIGHTNESS_EN
      data_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      oob_q      <= oob_d;
      rsp_rdy_q  <= rsp_rdy_d;
      rsp_data_q <= rsp_data_d;
`ifdef FB_BRIGHTNESS_EN
      data_q     <= data_d;
`endif
    end
  end

  assign rsp_rdy  = rsp_rdy_q;
  assign rsp_data = rsp_data_q;

endmodule
